// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 format constants and FSM state type.
// Shared by fp16_add and fp_double_adder.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef enum logic [1:0] {
    IDLE,
    ADD_AB,
    ADD_C,
    FIN
  } state_e;

endpackage

// File: rtl/fp16_add.sv
// fp16_add: combinational binary16 adder, RNE rounding.
// FP_ADD_SUBNORMAL_EN: gradual underflow; else flush-to-zero.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  output logic [15:0] z_o
);

  localparam int MW = FRAC_W + 1;
  localparam int XW = MW + 3;

  logic              sx, sy;
  logic [EXP_W-1:0]  ex, ey, exx, eyy;
  logic [FRAC_W-1:0] fx, fy;
  logic [MW-1:0]     mx, my;
  logic              nan_x, nan_y, inf_x, inf_y;
  logic              zero_x, zero_y;

  assign {sx, ex, fx} = x_i;
  assign {sy, ey, fy} = y_i;
  assign nan_x = (&ex) && (|fx);
  assign nan_y = (&ey) && (|fy);
  assign inf_x = (&ex) && !(|fx);
  assign inf_y = (&ey) && !(|fy);

`ifdef FP_ADD_SUBNORMAL_EN
  assign zero_x = !(|ex) && !(|fx);
  assign zero_y = !(|ey) && !(|fy);
  assign mx  = {|ex, fx};
  assign my  = {|ey, fy};
  assign exx = (|ex) ? ex : EXP_W'(1);
  assign eyy = (|ey) ? ey : EXP_W'(1);
`else
  assign zero_x = !(|ex);
  assign zero_y = !(|ey);
  assign mx  = {1'b1, fx};
  assign my  = {1'b1, fy};
  assign exx = ex;
  assign eyy = ey;
`endif

  logic             sl;
  logic [EXP_W-1:0] el, es, d;
  logic [MW-1:0]    ml, ms;
  logic [XW-1:0]    ext_s, al_raw, lost, al;
  logic [XW:0]      sum;
  logic [3:0]       lz, sh;
  logic [XW-1:0]    norm;
  logic [6:0]       eb, eo;
  logic [MW:0]      rnd;
  logic [FRAC_W-1:0] fo;
  logic             up, tiny;

  // Align, add/sub, normalise and round the finite nonzero path
  always_comb begin
    sl = sx; el = exx; ml = mx; es = eyy; ms = my;
    if ({eyy, my} > {exx, mx}) begin
      sl = sy; el = eyy; ml = my; es = exx; ms = mx;
    end
    d      = el - es;
    ext_s  = {ms, 3'b000};
    al_raw = ext_s >> d;
    lost   = ext_s & ~({XW{1'b1}} << d);
    al     = {al_raw[XW-1:1], al_raw[0] | (|lost)};
    if (sx ^ sy) sum = {1'b0, ml, 3'b000} - {1'b0, al};
    else         sum = {1'b0, ml, 3'b000} + {1'b0, al};
    lz = 4'(XW);
    for (int i = 0; i < XW; i++)
      if (sum[i]) lz = 4'(XW - 1 - i);
    tiny = 1'b0;
    sh   = lz;
    eb   = {2'b00, el} - {3'b000, lz};
    if (sum[XW]) begin
      norm = sum[XW:1] | {{(XW-1){1'b0}}, sum[0]};
      eb   = {2'b00, el} + 7'd1;
    end else begin
      if ({2'b00, el} <= {3'b000, lz}) begin
`ifdef FP_ADD_SUBNORMAL_EN
        sh = 4'(el - EXP_W'(1));
        eb = 7'd1;
`else
        tiny = 1'b1;
`endif
      end
      norm = sum[XW-1:0] << sh;
    end
    up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[XW-1:3]} + {{MW{1'b0}}, up};
    if (rnd[MW]) begin
      eo = eb + 7'd1;
      fo = rnd[MW-1:1];
    end else if (rnd[MW-1]) begin
      eo = eb;
      fo = rnd[FRAC_W-1:0];
    end else begin
      eo = 7'd0;
      fo = rnd[FRAC_W-1:0];
    end
  end

  // Special-case priority ahead of the arithmetic result
  always_comb begin
    if (nan_x || nan_y || (inf_x && inf_y && (sx ^ sy)))
      z_o = QNAN;
    else if (inf_x)
      z_o = x_i;
    else if (inf_y)
      z_o = y_i;
    else if (zero_x && zero_y)
      z_o = {sx & sy, 15'd0};
    else if (zero_x)
      z_o = y_i;
    else if (zero_y)
      z_o = x_i;
    else if (sum == '0)
      z_o = 16'h0000;
    else if (tiny)
      z_o = {sl, 15'd0};
    else if (eo >= 7'd31)
      z_o = sl ? NEG_INF : POS_INF;
    else
      z_o = {sl, eo[EXP_W-1:0], fo};
  end

endmodule

// File: rtl/fp_double_adder.sv
// fp_double_adder: sequential z = (a + b) + c in binary16.
// Subnormal handling follows FP_ADD_SUBNORMAL_EN (see fp16_add).
module fp_double_adder
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] input_a,
  input  logic [15:0] input_b,
  input  logic [15:0] input_c,
  output logic [15:0] output_z,
  output logic        done,
  output logic        ack
);

  state_e      state_q;
  logic [15:0] a_q, b_q, c_q, s1_q, z_q;
  logic        done_q, ack_q;
  logic [15:0] op_x, op_y, sum_d;

  assign op_x = (state_q == ADD_C) ? s1_q : a_q;
  assign op_y = (state_q == ADD_C) ? c_q : b_q;

  fp16_add u_add (
    .x_i (op_x),
    .y_i (op_y),
    .z_o (sum_d)
  );

  // Control FSM with operand latches and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      s1_q    <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= input_a;
            b_q     <= input_b;
            c_q     <= input_c;
            ack_q   <= 1'b0;
            state_q <= ADD_AB;
          end
        end
        ADD_AB: begin
          s1_q    <= sum_d;
          state_q <= ADD_C;
        end
        ADD_C: begin
          z_q     <= sum_d;
          done_q  <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= FIN;
        end
        FIN: begin
          done_q <= 1'b0;
          if (!start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign output_z = z_q;
  assign done     = done_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_fp_double_adder.sv
// tb_fp_double_adder: scoreboard bench against a real-arithmetic model.
// Expectations track FP_ADD_SUBNORMAL_EN the same way as the design.
module tb_fp_double_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] input_a = '0;
  logic [15:0] input_b = '0;
  logic [15:0] input_c = '0;
  logic [15:0] output_z;
  logic        done, ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic done_prev = 1'b0;
  logic [15:0] sb[$];

  fp_double_adder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .input_a  (input_a),
    .input_b  (input_b),
    .input_c  (input_c),
    .output_z (output_z),
    .done     (done),
    .ack      (ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_zero(input logic [15:0] h);
`ifdef FP_ADD_SUBNORMAL_EN
    return h[14:0] == 15'd0;
`else
    return h[14:10] == 5'd0;
`endif
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (is_zero(h)) v = 0.0;
    else if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
    else v = real'(1024 + h[9:0]) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  // Round an exact nonzero real to binary16, nearest-even
  function automatic logic [15:0] r2h(input real x);
    logic s;
    real ax, q, fr;
    int e, n;
    s  = x < 0.0;
    ax = s ? -x : x;
`ifndef FP_ADD_SUBNORMAL_EN
    if (ax < pow2(-14)) return {s, 15'd0};
`endif
    e = 16;
    while (e > -14 && ax < pow2(e)) e--;
    q  = ax / pow2(e - 10);
    n  = $rtoi(q);
    fr = q - real'(n);
    if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
    if (n >= 2048) begin
      n = n / 2;
      e++;
    end
    if (e > 15) return {s, 15'h7C00};
    if (n >= 1024) return {s, 5'(e + 15), 10'(n - 1024)};
    return {s, 5'd0, 10'(n)};
  endfunction

  function automatic logic [15:0] add_h(input logic [15:0] x, input logic [15:0] y);
    bit nx, ny, ix, iy;
    real sum;
    nx = x[14:10] == 5'h1F && x[9:0] != 0;
    ny = y[14:10] == 5'h1F && y[9:0] != 0;
    ix = x[14:10] == 5'h1F && x[9:0] == 0;
    iy = y[14:10] == 5'h1F && y[9:0] == 0;
    if (nx || ny || (ix && iy && x[15] != y[15])) return 16'h7E00;
    if (ix) return x;
    if (iy) return y;
    if (is_zero(x) && is_zero(y)) return {x[15] & y[15], 15'd0};
    sum = h2r(x) + h2r(y);
    if (sum == 0.0) return 16'h0000;
    return r2h(sum);
  endfunction

  function automatic logic [15:0] rnd_h();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 9))
      0: h[14:10] = 5'h1F;
      1: h[14:10] = 5'h00;
      2: h[14:10] = 5'h1E;
      3: ;
      default: h[14:10] = 5'($urandom_range(8, 20));
    endcase
    return h;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] s1e,
                       input logic [15:0] ze, input int hold);
    @(negedge clk);
    input_a = a;
    input_b = b;
    input_c = c;
    start = 1'b1;
    sb.push_back(ze);
    @(posedge clk);
    acc_cyc = cyc + 1;
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear got %b want 0", ack);
    end
    input_a = 16'($urandom);
    input_b = 16'($urandom);
    input_c = 16'($urandom);
    @(posedge clk);
    #1;
    checks++;
    if (dut.s1_q !== s1e) begin
      errors++;
      $display("FAIL s1 a=%h b=%h got %h want %h", a, b, dut.s1_q, s1e);
    end
    for (int k = 2; k < hold; k++) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout no done got %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] c, input int hold);
    logic [15:0] s1;
    s1 = add_h(a, b);
    issue(a, b, c, s1, add_h(s1, c), hold);
  endtask

  task automatic check16(input string nm, input logic [15:0] got,
                         input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: pop and compare on every done pulse
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        checks++;
        if (done_prev) begin
          errors++;
          $display("FAIL done_width got 2+ cycles want 1");
        end
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_done z=%h got pulse want none", output_z);
        end else begin
          e = sb.pop_front();
          check16("output_z", output_z, e);
          checks++;
          if (ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_set got %b want 1", ack);
          end
          checks++;
          if (cyc - acc_cyc != 2) begin
            errors++;
            $display("FAIL latency got %0d want 2", cyc - acc_cyc);
          end
        end
      end
      done_prev = done;
    end
  end

  initial begin
    logic [15:0] a, b, c, s1, sub_exp;
    repeat (3) @(negedge clk);
    check16("rst_z", output_z, 16'h0000);
    check16("rst_done", {15'd0, done}, 16'd0);
    check16("rst_ack", {15'd0, ack}, 16'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    issue(16'hB1C2, 16'hB266, 16'hB800, 16'hB614, 16'hBB0A, 2);
    issue(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 16'h4200, 3);
    repeat (5) @(negedge clk);
    check16("ack_hold", {15'd0, ack}, 16'd1);
    check16("z_hold", output_z, 16'h4200);
    issue(16'h7C00, 16'hFC00, 16'h3C00, 16'h7E00, 16'h7E00, 2);
    issue(16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 16'h7C00, 2);
    issue(16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 16'h0000, 2);
    issue(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 5);
`ifdef FP_ADD_SUBNORMAL_EN
    sub_exp = 16'h0002;
`else
    sub_exp = 16'h0000;
`endif
    issue(16'h0001, 16'h0001, 16'h0000, sub_exp, sub_exp, 2);
    issue(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000, 16'h4200, 2);

    // Reset while in ADD_C: no pulse may follow
    @(negedge clk);
    input_a = 16'h4000;
    input_b = 16'h4000;
    input_c = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    #1;
    check16("abort_z", output_z, 16'h0000);
    check16("abort_done", {15'd0, done}, 16'd0);
    check16("abort_ack", {15'd0, ack}, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check16("post_abort_z", output_z, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      a = rnd_h();
      b = ($urandom_range(0, 3) == 0)
          ? (a ^ 16'h8000 ^ 16'($urandom_range(0, 3))) : rnd_h();
      s1 = add_h(a, b);
      c = ($urandom_range(0, 4) == 0) ? (s1 ^ 16'h8000) : rnd_h();
      run(a, b, c, $urandom_range(2, 5));
    end

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_double_adder.md
# fp_double_adder

Sequential three-operand IEEE-754 binary16 (half-precision) adder computing z = (a + b) + c. It serves as an accumulation primitive in the MDP value-update datapath. Operands are captured on a start request. Two rounded additions run back-to-back through one shared adder. The result is presented with a one-cycle done pulse and a level ack.

## Interface
- Parameters: none (formats are fixed constants in the shared package).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  in  1  operation request, level-sampled in IDLE.
- input_a  in  16  binary16 operand a.
- input_b  in  16  binary16 operand b.
- input_c  in  16  binary16 operand c.
- output_z  out  16  binary16 result, registered.
- done  out  1  one-cycle pulse when output_z is first valid.
- ack  out  1  high while output_z holds a valid result, until the next accepted start.

## Operation
- FSM states: IDLE, ADD_AB, ADD_C, FIN.
- IDLE: when start=1, latch input_a/b/c, clear ack, go to ADD_AB.
- ADD_AB: s1 = round(a + b) into an internal register, then go to ADD_C.
- ADD_C: output_z = round(s1 + c); set done=1 and ack=1; go to FIN.
- FIN: done=0. Stay while start=1; return to IDLE when start=0. A start held high therefore triggers exactly one operation.
- Inputs are sampled only in IDLE on the accepting edge. Input changes at any other time are ignored.
- Arithmetic: IEEE binary16 (1 sign bit, 5 exponent bits with bias 15, 10 fraction bits).
  - Each addition is rounded separately with round-to-nearest-even, using guard, round and sticky bits.
- Effective subtraction aligns to the larger magnitude; the result sign is the sign of the larger magnitude.
- Zero rules:
  - Exact cancellation gives +0.
  - (-0) + (-0) gives -0.
- Overflow after rounding gives ±inf (exponent 31, fraction 0).
- NaN or (+inf) + (-inf) anywhere in the chain gives canonical qNaN 16'h7E00.
- inf + finite gives that inf.
- Reset values: output_z=16'h0000, done=0, ack=0, state IDLE, internal registers 0.
- A reset during any state aborts the operation immediately; no done pulse follows.

## Timing
- Edge 0 is the edge where start is accepted in IDLE.
- Edge 1: s1 is registered.
- Edge 2: output_z is registered; done=1 and ack=1 for the following cycle.
- Latency is 2 cycles from the accepting edge to output_z valid. done is high for exactly one cycle.
- Minimum issue interval is 3 cycles plus one cycle of start=0.
- output_z and ack stay stable until the next accepted start, which clears ack on edge 0.

## Configuration
- FP_ADD_SUBNORMAL_EN defined: full gradual-underflow support. Subnormal inputs use a hidden bit of 0 and exponent 1; tiny results are denormalised and rounded.
- FP_ADD_SUBNORMAL_EN undefined: flush-to-zero. Subnormal inputs are treated as signed zero, and results below the minimum normal become signed zero.

## Structure
- Package fp16_pkg holds:
  - widths EXP_W=5, FRAC_W=10, BIAS=15;
  - constants QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00;
  - the FSM state enum.
- Sub-module fp16_add: combinational two-operand binary16 adder. Stages are unpack, special-case detect, align with sticky, add/sub, leading-zero normalise, RNE round, pack. It is instantiated once, with operand muxes steered by the FSM state.
- The top level contains only the FSM, input latches, the s1 register and the output registers.

## Test plan
- a=16'hB1C2, b=16'hB266, c=16'hB800, start high for 2 cycles, then:
  - s1=16'hB614;
  - output_z=16'hBB0A two edges after acceptance;
  - one done pulse only.
- a=b=c=16'h3C00 (1.0) -> output_z=16'h4200 (3.0); ack stays high until the next start.
- a=16'h7C00, b=16'hFC00, c=16'h3C00 -> output_z=16'h7E00.
- a=16'h7BFF, b=16'h7BFF, c=16'h0000 -> output_z=16'h7C00 (overflow).
- a=16'h3C00, b=16'hBC00, c=16'h0000 -> output_z=16'h0000 (+0). a=b=c=16'h8000 -> 16'h8000.
- a=b=16'h0001, c=16'h0000 -> 16'h0002 with FP_ADD_SUBNORMAL_EN, 16'h0000 without.
- Reset pulled low in ADD_C -> output_z=0, done=0, ack=0, no done pulse after release.
